ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
Two-port round-robin arbiter and sequencer for the single-port RAM core.
- Accepts read/write requests from two independent requesters (A, B) using a req/ack handshake.
- Serialises requests onto the RAM core's cs/we/oe/addr/data interface.
- Returns read data to the requester that issued the read.
- Sits between the on-chip masters and the RAM core, inside the pad ring.

Parameters:
ADDRWIDTH, 4, RAM address width
DATAWIDTH, 8, RAM data width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
a_req  input  1  requester A request, held until a_ack
a_we  input  1  A: 1 = write, 0 = read
a_addr  input  ADDRWIDTH  A address
a_wdata  input  DATAWIDTH  A write data
a_ack  output  1  A completion pulse, one cycle
a_rdata  output  DATAWIDTH  A read data, valid while a_ack=1 on a read
b_req, b_we, b_addr, b_wdata, b_ack, b_rdata  same as A, for requester B
ram_cs  output  1  RAM chip select
ram_we  output  1  RAM write enable
ram_oe  output  1  RAM output enable
ram_addr  output  ADDRWIDTH  RAM address
ram_wdata  output  DATAWIDTH  data driven onto RAM bus
ram_wdata_en  output  1  tristate drive enable for ram_wdata
ram_rdata  input  DATAWIDTH  data bus value read back from RAM

Behaviour:
Clock, reset and outputs
- Single clock domain on clk. rst is synchronous and active-high.
- All outputs are registered.
- While rst=1, and in the cycle after rst is sampled: all outputs are 0, FSM is in IDLE, last_gnt=B.

State machine (IDLE, ACCESS, RDWAIT, ACK)
- Requests are sampled only in IDLE.
- Requesters must hold req/we/addr/wdata stable from assertion until ack.
- Arbitration in IDLE:
  - Only A requesting: grant A.
  - Only B requesting: grant B.
  - Both requesting: grant the requester that is not last_gnt.
  - last_gnt updates on every grant.
  - After reset, A wins the first tie.
- IDLE -> ACCESS on any grant. At that edge, latch the winner's we, addr and wdata into ram_addr/ram_wdata.
- ACCESS, write:
  - ram_cs=1, ram_we=1, ram_oe=0, ram_wdata_en=1.
  - RAM captures the write at the end of this cycle.
  - Next state: ACK.
- ACCESS, read:
  - ram_cs=1, ram_we=0, ram_oe=1, ram_wdata_en=0.
  - Next state: RDWAIT.
- RDWAIT:
  - ram_cs=1, ram_oe=1.
  - ram_rdata is captured into the granted requester's rdata register at the end of this cycle.
  - Next state: ACK.
- ACK:
  - The granted requester's ack=1 for exactly one cycle.
  - ram_cs/we/oe/wdata_en=0.
  - Next state: IDLE.
- The requester must deassert req in the cycle following its ack, unless it is issuing a new request.

Latency and throughput
- Write: 3 cycles from req sampled in IDLE to ack.
- Read: 4 cycles from req sampled in IDLE to ack.
- Back-to-back: one request completes every 3 cycles (write) or 4 cycles (read).

Invariants
- ram_oe and ram_wdata_en are never 1 in the same cycle.
- At least one cycle with both low separates a read from a following write (bus turnaround).
- ram_addr and ram_wdata hold their last value when idle.
- x_rdata holds its value until the next read for that requester.
- The non-granted requester's ack stays 0.
- ram_we=1 only in ACCESS for writes.

Boundary conditions
- Reset mid-operation: the transaction is abandoned, no ack is issued, and outputs are 0 on the next cycle.
- A request arriving during ACCESS/RDWAIT/ACK waits for the next IDLE.
- A requester that holds req continuously with a different address each time is served alternately with the other requester (no starvation).

Test Plan:
- Reset, then A write addr=4'h3 data=8'hA5 -> ram_cs=ram_we=ram_wdata_en=1 with ram_addr=3, ram_wdata=A5 exactly one cycle; a_ack pulse 2 cycles after ACCESS; b_ack stays 0.
- Following the write, B read addr=4'h3 (RAM model returns A5) -> ram_oe=1 two cycles, ram_we=0; b_ack with b_rdata=8'hA5, 4 cycles after req sampled.
- A and B both request in the same cycle after reset -> A granted first, B granted at the next IDLE; repeated ties alternate A, B, A, B.
- A continuously requesting reads, B requests once -> B served no later than the second grant after its req; no starvation.
- Read followed immediately by write from the other requester -> at least one cycle with ram_oe=0 and ram_wdata_en=0 between them; never both 1.
- Assert rst during RDWAIT -> next cycle all outputs 0; no ack; a fresh request after reset completes normally and A wins the first tie.

Source files
------------

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Brief    : Round-robin two-requester arbiter and sequencer for a single-port RAM.
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
    parameter int ADDRWIDTH = 4,
    parameter int DATAWIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_req,
    input  logic                 a_we,
    input  logic [ADDRWIDTH-1:0] a_addr,
    input  logic [DATAWIDTH-1:0] a_wdata,
    output logic                 a_ack,
    output logic [DATAWIDTH-1:0] a_rdata,
    input  logic                 b_req,
    input  logic                 b_we,
    input  logic [ADDRWIDTH-1:0] b_addr,
    input  logic [DATAWIDTH-1:0] b_wdata,
    output logic                 b_ack,
    output logic [DATAWIDTH-1:0] b_rdata,
    output logic                 ram_cs,
    output logic                 ram_we,
    output logic                 ram_oe,
    output logic [ADDRWIDTH-1:0] ram_addr,
    output logic [DATAWIDTH-1:0] ram_wdata,
    output logic                 ram_wdata_en,
    input  logic [DATAWIDTH-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RDWAIT = 2'd2,
        S_ACK    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic r_last_gnt;   // 0 = A, 1 = B
    logic r_gnt;
    logic r_op_we;

    logic w_grant;
    logic w_sel;
    logic w_sel_we;
    logic w_cs_nxt;
    logic w_we_nxt;
    logic w_oe_nxt;
    logic w_wen_nxt;
    logic w_a_ack_nxt;
    logic w_b_ack_nxt;

    // Every output is a flop, so the comb block computes the value each
    // output must hold while the FSM sits in the next state.
    always_comb begin
        w_grant     = a_req | b_req;
        w_sel       = (a_req & b_req) ? ~r_last_gnt : b_req;
        w_sel_we    = w_sel ? b_we : a_we;
        w_state_nxt = r_state;
        w_cs_nxt    = 1'b0;
        w_we_nxt    = 1'b0;
        w_oe_nxt    = 1'b0;
        w_wen_nxt   = 1'b0;
        w_a_ack_nxt = 1'b0;
        w_b_ack_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = S_ACCESS;
                    w_cs_nxt    = 1'b1;
                    w_we_nxt    = w_sel_we;
                    w_oe_nxt    = ~w_sel_we;
                    w_wen_nxt   = w_sel_we;
                end
            end
            S_ACCESS: begin
                if (r_op_we) begin
                    w_state_nxt = S_ACK;
                    w_a_ack_nxt = ~r_gnt;
                    w_b_ack_nxt = r_gnt;
                end else begin
                    w_state_nxt = S_RDWAIT;
                    w_cs_nxt    = 1'b1;
                    w_oe_nxt    = 1'b1;
                end
            end
            S_RDWAIT: begin
                w_state_nxt = S_ACK;
                w_a_ack_nxt = ~r_gnt;
                w_b_ack_nxt = r_gnt;
            end
            S_ACK: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_gnt   <= 1'b1;
            r_gnt        <= 1'b0;
            r_op_we      <= 1'b0;
            ram_cs       <= 1'b0;
            ram_we       <= 1'b0;
            ram_oe       <= 1'b0;
            ram_wdata_en <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            a_ack        <= 1'b0;
            b_ack        <= 1'b0;
            a_rdata      <= '0;
            b_rdata      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            ram_cs       <= w_cs_nxt;
            ram_we       <= w_we_nxt;
            ram_oe       <= w_oe_nxt;
            ram_wdata_en <= w_wen_nxt;
            a_ack        <= w_a_ack_nxt;
            b_ack        <= w_b_ack_nxt;
            if (r_state == S_IDLE && w_grant) begin
                r_gnt      <= w_sel;
                r_last_gnt <= w_sel;
                r_op_we    <= w_sel_we;
                ram_addr   <= w_sel ? b_addr : a_addr;
                ram_wdata  <= w_sel ? b_wdata : a_wdata;
            end
            // Read data lands in the owner's register as RDWAIT ends.
            if (r_state == S_RDWAIT) begin
                if (r_gnt) begin
                    b_rdata <= ram_rdata;
                end else begin
                    a_rdata <= ram_rdata;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Brief    : Directed scoreboard bench for ram_arbiter with a behavioural RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;
    localparam int AW = 4;
    localparam int DW = 8;

    typedef struct packed {
        logic          who;   // 0 = A, 1 = B
        logic          rd;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_req = 1'b0, a_we = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_wdata = '0;
    logic          a_ack;
    logic [DW-1:0] a_rdata;
    logic          b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic          b_ack;
    logic [DW-1:0] b_rdata;
    logic          ram_cs, ram_we, ram_oe, ram_wdata_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    logic [DW-1:0] mem     [16];
    logic [DW-1:0] ref_mem [16];
    exp_t          sb[$];
    int            n_cmp = 0;
    int            n_err = 0;
    bit            mon_en = 1'b0;
    bit            prev_oe = 1'b0;

    ram_arbiter #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_wdata_en(ram_wdata_en), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM
    assign ram_rdata = ram_oe ? mem[ram_addr] : '0;
    always @(posedge clk) begin
        if (ram_cs && ram_we) mem[ram_addr] <= ram_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic who, input logic rd, input logic [DW-1:0] d);
        exp_t e;
        e.who  = who;
        e.rd   = rd;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Completion monitor and bus invariants, sampled on the falling edge
    always @(negedge clk) begin : mon
        exp_t e;
        if (mon_en) begin
            check("oe_wen_excl", {31'd0, ram_oe & ram_wdata_en}, 32'd0);
            check("turnaround", {31'd0, prev_oe & ram_wdata_en}, 32'd0);
            check("we_only_write", {31'd0, ram_we & ~ram_wdata_en}, 32'd0);
            check("ack_excl", {31'd0, a_ack & b_ack}, 32'd0);
            prev_oe = ram_oe;
            if (a_ack || b_ack) begin
                if (sb.size() == 0) begin
                    check("ack_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("ack_who", {31'd0, b_ack}, {31'd0, e.who});
                    if (e.rd) check("ack_rdata", {24'd0, e.who ? b_rdata : a_rdata}, {24'd0, e.data});
                end
            end
        end
    end

    initial begin
        int na, nb, g_b;
        bit b_on;
        for (int i = 0; i < 16; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end

        // Reset
        tick(); tick();
        check("reset_ctrl", {26'd0, ram_cs, ram_we, ram_oe, ram_wdata_en, a_ack, b_ack}, 32'd0);
        check("reset_data", {4'd0, ram_addr, ram_wdata, a_rdata, b_rdata}, 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        // A write 3 <- A5
        a_req = 1'b1; a_we = 1'b1; a_addr = 4'h3; a_wdata = 8'hA5;
        push(1'b0, 1'b0, 8'h00); ref_mem[3] = 8'hA5;
        tick();
        check("wr_access_ctrl", {28'd0, ram_cs, ram_we, ram_oe, ram_wdata_en}, 32'b1101);
        check("wr_access_bus", {20'd0, ram_addr, ram_wdata}, {20'd0, 4'h3, 8'hA5});
        check("wr_access_noack", {30'd0, a_ack, b_ack}, 32'd0);
        tick();
        check("wr_ack", {29'd0, a_ack, b_ack, ram_cs}, 32'b100);
        a_req = 1'b0;
        tick();
        check("wr_ack_pulse", {30'd0, a_ack, ram_cs}, 32'd0);

        // B read 3
        b_req = 1'b1; b_we = 1'b0; b_addr = 4'h3;
        push(1'b1, 1'b1, ref_mem[3]);
        tick();
        check("rd_access_ctrl", {28'd0, ram_cs, ram_we, ram_oe, ram_wdata_en}, 32'b1010);
        check("rd_access_addr", {28'd0, ram_addr}, 32'h3);
        tick();
        check("rd_wait_ctrl", {28'd0, ram_cs, ram_we, ram_oe, ram_wdata_en}, 32'b1010);
        tick();
        check("rd_ack", {29'd0, a_ack, b_ack, ram_oe}, 32'b010);
        check("rd_data", {24'd0, b_rdata}, 32'hA5);
        b_req = 1'b0;
        tick();

        // Ties after a fresh reset alternate A, B, A, B
        rst = 1'b1;
        tick();
        check("reset2_ctrl", {26'd0, ram_cs, ram_we, ram_oe, ram_wdata_en, a_ack, b_ack}, 32'd0);
        rst = 1'b0;
        a_req = 1'b1; a_we = 1'b1; a_addr = 4'h4; a_wdata = 8'h40;
        b_req = 1'b1; b_we = 1'b1; b_addr = 4'h8; b_wdata = 8'h80;
        push(1'b0, 1'b0, 8'h00); push(1'b1, 1'b0, 8'h00);
        ref_mem[4] = 8'h40; ref_mem[8] = 8'h80;
        na = 0; nb = 0;
        for (int t = 0; t < 40 && (na < 2 || nb < 2); t++) begin
            tick();
            if (a_ack) begin
                na++;
                if (na < 2) begin
                    a_addr = 4'h5; a_wdata = 8'h41; push(1'b0, 1'b0, 8'h00); ref_mem[5] = 8'h41;
                end else a_req = 1'b0;
            end
            if (b_ack) begin
                nb++;
                if (nb < 2) begin
                    b_addr = 4'h9; b_wdata = 8'h81; push(1'b1, 1'b0, 8'h00); ref_mem[9] = 8'h81;
                end else b_req = 1'b0;
            end
        end
        check("tie_acks", na + nb, 32'd4);
        tick();
        for (int i = 4; i < 10; i++) begin
            if (i == 4 || i == 5 || i == 8 || i == 9)
                check($sformatf("mem_%0d", i), {24'd0, mem[i]}, {24'd0, ref_mem[i]});
        end

        // A reads back to back; B asks once and must not starve
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'h4;
        push(1'b0, 1'b1, ref_mem[4]);
        na = 0; nb = 0; g_b = 0; b_on = 1'b0;
        for (int t = 0; t < 60 && (na < 3 || nb < 1); t++) begin
            tick();
            if (a_ack) begin
                na++;
                if (b_on && nb == 0) g_b++;
                if (na == 1) begin
                    b_req = 1'b1; b_we = 1'b0; b_addr = 4'h9; b_on = 1'b1;
                    push(1'b1, 1'b1, ref_mem[9]);
                end
                if (na < 3) begin
                    a_addr = (na == 1) ? 4'h5 : 4'h8;
                    push(1'b0, 1'b1, ref_mem[a_addr]);
                end else a_req = 1'b0;
            end
            if (b_ack) begin
                nb++; g_b++; b_req = 1'b0;
            end
        end
        check("starve_acks", na + nb, 32'd4);
        check("starve_b_grant", g_b, 32'd1);
        tick();

        // A read then B write queued behind it: bus turnaround
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'h5;
        push(1'b0, 1'b1, ref_mem[5]);
        tick();
        b_req = 1'b1; b_we = 1'b1; b_addr = 4'h6; b_wdata = 8'h66;
        push(1'b1, 1'b0, 8'h00); ref_mem[6] = 8'h66;
        na = 0; nb = 0;
        for (int t = 0; t < 30 && (na < 1 || nb < 1); t++) begin
            tick();
            if (a_ack) begin na++; a_req = 1'b0; end
            if (b_ack) begin nb++; b_req = 1'b0; end
        end
        check("rdwr_acks", na + nb, 32'd2);
        tick();
        check("mem_6", {24'd0, mem[6]}, 32'h66);

        // Reset during RDWAIT abandons the read
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'h6;
        push(1'b0, 1'b1, ref_mem[6]);
        tick(); tick();
        check("rdwait_ctrl", {30'd0, ram_cs, ram_oe}, 32'b11);
        rst = 1'b1; a_req = 1'b0;
        sb.delete();
        tick();
        check("rst_mid_ctrl", {26'd0, ram_cs, ram_we, ram_oe, ram_wdata_en, a_ack, b_ack}, 32'd0);
        check("rst_mid_data", {4'd0, ram_addr, ram_wdata, a_rdata, b_rdata}, 32'd0);
        tick();
        rst = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'h6;
        b_req = 1'b1; b_we = 1'b0; b_addr = 4'h3;
        push(1'b0, 1'b1, ref_mem[6]); push(1'b1, 1'b1, ref_mem[3]);
        na = 0; nb = 0;
        for (int t = 0; t < 30 && (na < 1 || nb < 1); t++) begin
            tick();
            if (a_ack) begin na++; a_req = 1'b0; end
            if (b_ack) begin nb++; b_req = 1'b0; end
        end
        check("post_rst_acks", na + nb, 32'd2);

        tick(); tick(); tick();
        check("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
